// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 scan-code set 2 decoder.
//   - prefix bytes (E0 extended, F0 break, E1 pause)
//   - controller/status bytes that never represent a key
//   - main-row and keypad digit scan codes, indexed by digit value
//   - decoder FSM state enum
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_OVR0   = 8'h00;
  localparam logic [7:0] SC_OVR1   = 8'hFF;

  // Bytes following E1 before the pause sequence is complete.
  localparam int unsigned PAUSE_SKIP = 7;

  localparam int unsigned N_DIGITS = 10;
  // Element [i] is the scan code of digit i.
  localparam logic [N_DIGITS-1:0][7:0] DIGIT_MAIN =
    {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
  localparam logic [N_DIGITS-1:0][7:0] DIGIT_PAD =
    {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } ps2_state_e;

  function automatic logic is_prefix(input logic [7:0] code);
    return (code == SC_EXT) || (code == SC_BRK) || (code == SC_PAUSE);
  endfunction

  function automatic logic is_ignored(input logic [7:0] code);
    return (code == SC_BAT_OK) || (code == SC_ACK) || (code == SC_RESEND) ||
           (code == SC_ECHO)   || (code == SC_OVR0) || (code == SC_OVR1);
  endfunction

endpackage

// File: rtl/ps2_digit_lut.sv
// ps2_digit_lut: combinational scan code -> digit value.
//   i_code    : scan code
//   i_ext     : code was E0-extended (extended keys never map to a digit)
//   o_digit_c : 0..9 for main-row / keypad digit keys, else 4'hF
module ps2_digit_lut
  import ps2_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  output logic [3:0] o_digit_c
);

  always_comb begin
    o_digit_c = 4'hF;
    if (!i_ext) begin
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        if ((i_code == DIGIT_MAIN[i]) || (i_code == DIGIT_PAD[i])) begin
          o_digit_c = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: assembles PS/2 set-2 byte sequences (E0/F0/E1 prefixes)
// into single-cycle make/break events with an optional auto-repeat filter.
// Optional feature: define PS2_DECODER_TYPEMATIC_FILTER_EN to suppress repeated
// makes of the key currently held down.
// Ports:
//   CLOCK_50, resetn (sync, active low)
//   received_data[7:0], received_data_en : byte stream from the PS/2 receiver
//   key_code[7:0], key_ext, key_digit[3:0] : last emitted event (held)
//   key_make, key_break, seq_error        : one-cycle pulses
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_make,
  output logic       key_break,
  output logic [3:0] key_digit,
  output logic       seq_error
);

  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SKIP_W = 3;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX   = '1;

  ps2_state_e        r_state;
  logic [TO_W-1:0]   r_to_cnt;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic [7:0]        r_key_code;
  logic              r_key_ext;
  logic [3:0]        r_key_digit;
  logic              r_key_make;
  logic              r_key_break;
  logic              r_seq_error;

  logic       w_prefix;
  logic       w_ignored;
  logic       w_ev_ext;
  logic [7:0] w_ev_code;
  logic [3:0] w_ev_digit;
  logic       w_pause_done;
  logic       w_make_req;
  logic       w_make_fire;
  logic       w_break_req;
  logic       w_bad_prefix;

  assign w_prefix  = is_prefix(received_data);
  assign w_ignored = is_ignored(received_data);

  // Event payload: a completed pause sequence always reports E1.
  assign w_ev_ext     = (r_state == EXT) || (r_state == EXT_BRK);
  assign w_ev_code    = (r_state == PAUSE) ? SC_PAUSE : received_data;
  assign w_pause_done = (r_state == PAUSE) && (r_skip_cnt == SKIP_W'(1));

  assign w_make_req = received_data_en &&
                      (((r_state == IDLE) && !w_prefix && !w_ignored) ||
                       ((r_state == EXT) && !w_prefix) || w_pause_done);
  assign w_break_req = received_data_en && !w_prefix &&
                       ((r_state == BRK) || (r_state == EXT_BRK));
  // Any prefix mid-sequence except the legal E0 F0 pair.
  assign w_bad_prefix = received_data_en && w_prefix &&
                        ((r_state == BRK) || (r_state == EXT_BRK) ||
                         ((r_state == EXT) && (received_data != SC_BRK)));

`ifdef PS2_DECODER_TYPEMATIC_FILTER_EN
  logic [7:0] r_held_code;
  logic       r_held_ext;
  logic       r_held_valid;
  logic       w_held_match;

  assign w_held_match = r_held_valid && (r_held_code == w_ev_code) && (r_held_ext == w_ev_ext);
  assign w_make_fire  = w_make_req && !w_held_match;

  // Held-key register: loaded by each emitted make, cleared by its own break.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_held_code  <= 8'h00;
      r_held_ext   <= 1'b0;
      r_held_valid <= 1'b0;
    end else if (w_make_fire) begin
      r_held_code  <= w_ev_code;
      r_held_ext   <= w_ev_ext;
      r_held_valid <= 1'b1;
    end else if (w_break_req && w_held_match) begin
      r_held_valid <= 1'b0;
    end
  end
`else
  assign w_make_fire = w_make_req;
`endif

  ps2_digit_lut u_digit_lut (
    .i_code    (w_ev_code),
    .i_ext     (w_ev_ext),
    .o_digit_c (w_ev_digit)
  );

  // Decoder FSM with timeout and registered event outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_to_cnt    <= '0;
      r_skip_cnt  <= '0;
      r_key_code  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_digit <= 4'hF;
      r_key_make  <= 1'b0;
      r_key_break <= 1'b0;
      r_seq_error <= 1'b0;
    end else begin
      r_key_make  <= w_make_fire;
      r_key_break <= w_break_req;
      r_seq_error <= w_bad_prefix;

      if (w_make_fire || w_break_req) begin
        r_key_code  <= w_ev_code;
        r_key_ext   <= w_ev_ext;
        r_key_digit <= w_ev_digit;
      end

      if (received_data_en) begin
        r_to_cnt <= '0;
        if (r_state == PAUSE) begin
          if (w_pause_done) begin
            r_state    <= IDLE;
            r_skip_cnt <= '0;
          end else begin
            r_skip_cnt <= r_skip_cnt - 1'b1;
          end
        end else if ((r_state == EXT) && (received_data == SC_BRK)) begin
          r_state <= EXT_BRK;
        end else if (w_prefix) begin
          // Start (or restart) a sequence from this prefix.
          if (received_data == SC_EXT) begin
            r_state <= EXT;
          end else if (received_data == SC_BRK) begin
            r_state <= BRK;
          end else begin
            r_state    <= PAUSE;
            r_skip_cnt <= SKIP_W'(PAUSE_SKIP);
          end
        end else begin
          r_state <= IDLE;
        end
      end else if (r_state != IDLE) begin
        if (r_to_cnt == TO_LIMIT) begin
          r_state     <= IDLE;
          r_to_cnt    <= '0;
          r_skip_cnt  <= '0;
          r_seq_error <= 1'b1;
        end else if (r_to_cnt != TO_MAX) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_ext   = r_key_ext;
  assign key_digit = r_key_digit;
  assign key_make  = r_key_make;
  assign key_break = r_key_break;
  assign seq_error = r_seq_error;

endmodule
